// File: rtl/chan_pkt_mover_if.sv
// chan_pkt_mover_if: bundles the arbiter grant, the input-FIFO heads and the
// cache write port seen by chan_pkt_mover.
//   i_chan_en/i_chan_sel   grant strobe and granted port index
//   i_port_data/_empty     first-word-fall-through FIFO heads and empty flags
//   o_port_rd              one-hot FIFO pop
//   i_wr_full              cache write almost-full
//   o_wr_*                 registered cache write port
//   o_end/o_busy           packet-done pulse and busy flag back to the arbiter
//   o_err                  timeout abort flag (only with MOVER_TIMEOUT_EN)
// Modports: slave = the mover itself, master = its surroundings.
interface chan_pkt_mover_if #(
  parameter int PORTNUM = 16,
  parameter int DWIDTH  = 64
);
  localparam int SEL_W = $clog2(PORTNUM);

  logic                      i_chan_en;
  logic [SEL_W-1:0]          i_chan_sel;
  logic [PORTNUM*DWIDTH-1:0] i_port_data;
  logic [PORTNUM-1:0]        i_port_empty;
  logic [PORTNUM-1:0]        o_port_rd;
  logic                      i_wr_full;
  logic                      o_wr_en;
  logic [DWIDTH-1:0]         o_wr_data;
  logic                      o_wr_sop;
  logic                      o_wr_eop;
  logic [SEL_W-1:0]          o_wr_port;
  logic                      o_end;
  logic                      o_busy;
`ifdef MOVER_TIMEOUT_EN
  logic                      o_err;
`endif

  modport slave (
`ifdef MOVER_TIMEOUT_EN
    output o_err,
`endif
    input  i_chan_en, i_chan_sel, i_port_data, i_port_empty, i_wr_full,
    output o_port_rd, o_wr_en, o_wr_data, o_wr_sop, o_wr_eop, o_wr_port,
           o_end, o_busy
  );

  modport master (
`ifdef MOVER_TIMEOUT_EN
    input  o_err,
`endif
    output i_chan_en, i_chan_sel, i_port_data, i_port_empty, i_wr_full,
    input  o_port_rd, o_wr_en, o_wr_data, o_wr_sop, o_wr_eop, o_wr_port,
           o_end, o_busy
  );
endinterface

// File: rtl/chan_pkt_mover.sv
// chan_pkt_mover: after a grant from the channel arbiter, drains one complete
// packet (header + len payload words, len taken from header[LEN_W-1:0]) from
// the selected FWFT input FIFO into the shared cache write port, then pulses
// o_end so the arbiter can grant the next channel.
// Ports:
//   i_clk   clock
//   i_rst   asynchronous active-high reset
//   bus     chan_pkt_mover_if.slave (grant, FIFO heads/pops, write port,
//           o_end/o_busy, o_err when built with MOVER_TIMEOUT_EN)
// Build option MOVER_TIMEOUT_EN: a 10-bit idle counter aborts a packet whose
// source FIFO stays empty for 1023 consecutive cycles, writing one zero word
// marked eop and flagging o_err alongside o_end.
//
// state | meaning
// IDLE  | waiting for a grant
// HDR   | popping the header word, loading the payload length
// DATA  | popping payload words until the length runs out
// DONE  | one-cycle o_end pulse, coincident with the eop write
module chan_pkt_mover #(
  parameter int PORTNUM = 16,
  parameter int DWIDTH  = 64,
  parameter int LEN_W   = 8
) (
  input logic             i_clk,
  input logic             i_rst,
  chan_pkt_mover_if.slave bus
);
  localparam int SEL_W = $clog2(PORTNUM);

  typedef enum logic [1:0] {ST_IDLE, ST_HDR, ST_DATA, ST_DONE} state_t;

  state_t             state_q, state_d;
  logic [SEL_W-1:0]   sel_q, sel_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic               wr_en_q, wr_en_d;
  logic [DWIDTH-1:0]  wr_data_q, wr_data_d;
  logic               wr_sop_q, wr_sop_d;
  logic               wr_eop_q, wr_eop_d;
  logic [SEL_W-1:0]   wr_port_q, wr_port_d;
  logic [PORTNUM-1:0] port_rd;
  logic [DWIDTH-1:0]  head_word;
  logic               head_empty;
  logic               xfer;
  logic               beat;
`ifdef MOVER_TIMEOUT_EN
  logic [9:0]         idle_cnt_q, idle_cnt_d;
  logic               err_q, err_d;
  logic               timeout;
`endif

  assign head_word  = bus.i_port_data[int'(sel_q)*DWIDTH +: DWIDTH];
  assign head_empty = bus.i_port_empty[sel_q];
  assign xfer       = (state_q == ST_HDR) || (state_q == ST_DATA);
  assign beat       = xfer && !head_empty && !bus.i_wr_full;

`ifdef MOVER_TIMEOUT_EN
  // idle_cnt_q == 1022 while still empty means this is the 1023rd empty cycle.
  assign timeout = xfer && head_empty && (idle_cnt_q == 10'd1022);
`endif

  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    len_d     = len_q;
    wr_en_d   = 1'b0;
    wr_data_d = wr_data_q;
    wr_sop_d  = 1'b0;
    wr_eop_d  = 1'b0;
    wr_port_d = sel_q;
    port_rd   = '0;
`ifdef MOVER_TIMEOUT_EN
    idle_cnt_d = (xfer && head_empty) ? idle_cnt_q + 10'd1 : 10'd0;
    err_d      = (state_q == ST_DONE) ? 1'b0 : err_q;
`endif

    if (beat) begin
      port_rd[sel_q] = 1'b1;
      wr_en_d        = 1'b1;
      wr_data_d      = head_word;
    end

    case (state_q)
      ST_IDLE: begin
        if (bus.i_chan_en) begin
          sel_d   = bus.i_chan_sel;
          state_d = ST_HDR;
        end
      end
      ST_HDR: begin
        if (beat) begin
          wr_sop_d = 1'b1;
          len_d    = head_word[LEN_W-1:0];
          if (head_word[LEN_W-1:0] == '0) begin
            wr_eop_d = 1'b1;
            state_d  = ST_DONE;
          end else begin
            state_d  = ST_DATA;
          end
        end
      end
      ST_DATA: begin
        if (beat) begin
          len_d = len_q - 1'b1;
          if (len_q == LEN_W'(1)) begin
            wr_eop_d = 1'b1;
            state_d  = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

`ifdef MOVER_TIMEOUT_EN
    // Timeout only fires on an empty FIFO, so it never collides with a beat.
    if (timeout) begin
      wr_en_d    = 1'b1;
      wr_data_d  = '0;
      wr_sop_d   = 1'b0;
      wr_eop_d   = 1'b1;
      err_d      = 1'b1;
      idle_cnt_d = 10'd0;
      state_d    = ST_DONE;
    end
`endif
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q   <= ST_IDLE;
      sel_q     <= '0;
      len_q     <= '0;
      wr_en_q   <= 1'b0;
      wr_data_q <= '0;
      wr_sop_q  <= 1'b0;
      wr_eop_q  <= 1'b0;
      wr_port_q <= '0;
    end else begin
      state_q   <= state_d;
      sel_q     <= sel_d;
      len_q     <= len_d;
      wr_en_q   <= wr_en_d;
      wr_data_q <= wr_data_d;
      wr_sop_q  <= wr_sop_d;
      wr_eop_q  <= wr_eop_d;
      wr_port_q <= wr_port_d;
    end
  end

`ifdef MOVER_TIMEOUT_EN
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      idle_cnt_q <= '0;
      err_q      <= 1'b0;
    end else begin
      idle_cnt_q <= idle_cnt_d;
      err_q      <= err_d;
    end
  end

  assign bus.o_err = (state_q == ST_DONE) && err_q;
`endif

  assign bus.o_port_rd = port_rd;
  assign bus.o_wr_en   = wr_en_q;
  assign bus.o_wr_data = wr_data_q;
  assign bus.o_wr_sop  = wr_sop_q;
  assign bus.o_wr_eop  = wr_eop_q;
  assign bus.o_wr_port = wr_port_q;
  assign bus.o_end     = (state_q == ST_DONE);
  assign bus.o_busy    = (state_q != ST_IDLE);
endmodule

// File: doc/chan_pkt_mover.md
Name: chan_pkt_mover

Overview:
- Datapath stage directly downstream of the channel arbiter.
- On a grant (`i_chan_en` with `i_chan_sel`), drains one complete packet from the selected input-port FIFO into the shared cache write port.
- Pulses `o_end` back to the arbiter when the packet's last word has been written, so the next channel can be granted.
- Packet length comes from the header word; all transfer timing is local to this block.

Parameters:
- PORTNUM, 16, number of input ports / FIFOs.
- DWIDTH, 64, data word width.
- LEN_W, 8, width of the header payload-length field (header bits [LEN_W-1:0]).

Ports:
- i_clk  in  1  clock.
- i_rst  in  1  reset; asynchronous, active-high.
- i_chan_en  in  1  grant strobe from arbiter, one cycle.
- i_chan_sel  in  $clog2(PORTNUM)  granted port index, valid with i_chan_en.
- i_port_data  in  PORTNUM*DWIDTH  first-word-fall-through FIFO heads; port p occupies slice [p*DWIDTH +: DWIDTH].
- i_port_empty  in  PORTNUM  FIFO empty flags.
- o_port_rd  out  PORTNUM  one-hot FIFO pop; at most one bit set.
- i_wr_full  in  1  cache write almost-full; slack of at least 2 words guaranteed by consumer.
- o_wr_en  out  1  cache write strobe.
- o_wr_data  out  DWIDTH  write data.
- o_wr_sop  out  1  marks header word.
- o_wr_eop  out  1  marks last word of packet.
- o_wr_port  out  $clog2(PORTNUM)  source port of current packet.
- o_end  out  1  one-cycle packet-done pulse to arbiter i_end.
- o_busy  out  1  high from grant acceptance until o_end.

Behaviour:
- Reset values: all outputs 0; state IDLE; latched sel 0; length counter 0.
- Reset asserted mid-packet aborts immediately. No o_end is issued; the FIFO is left partially drained, and system reset also clears the FIFOs.
- States: IDLE, HDR, DATA, DONE.
- IDLE:
  - i_chan_en=1 latches i_chan_sel into sel_q; o_busy=1 next cycle; go to HDR.
  - i_chan_en while not IDLE is ignored; the arbiter never issues one.
- Beat condition: beat = !i_port_empty[sel_q] && !i_wr_full. o_port_rd[sel_q] = beat, combinational; all other rd bits 0.
- HDR:
  - On beat, load len_q = header[LEN_W-1:0] (payload word count).
  - len=0: header is also the last word; go to DONE.
  - len>0: go to DATA.
- DATA:
  - Each beat decrements len_q.
  - The beat with len_q==1 is the last word; go to DONE.
  - No beat means stall with no state change, as often as needed.
- Write side is registered, so o_wr_* appears 1 cycle after the pop:
  - o_wr_en = beat delayed 1 cycle.
  - o_wr_data = the popped word.
  - o_wr_sop = 1 on the header beat.
  - o_wr_eop = 1 on the last beat.
  - o_wr_port = sel_q.
  - With len=0, sop and eop are both 1 on the same word.
- DONE (one cycle): o_end=1 and o_busy still 1; o_end coincides with o_wr_eop. Return to IDLE; o_busy=0 next cycle.
- Throughput: 1 word/cycle when unstalled. Grant to first o_wr_en is 2 cycles minimum. A packet of N payload words completes in N+1 beats.
- Boundary cases:
  - Max length 2^LEN_W-1 with no wrap.
  - i_port_empty and i_wr_full high together means a stall.
  - A FIFO going empty mid-packet stalls indefinitely unless the timeout option is built in.
  - A new grant arriving in the same cycle as o_end is not possible, because the arbiter waits for i_end. If one arrives the cycle after, it is accepted.

Optional Feature:
- Macro MOVER_TIMEOUT_EN.
- Defined:
  - A 10-bit idle counter counts consecutive cycles in HDR/DATA with i_port_empty[sel_q]=1; it is cleared on any beat.
  - Reaching 1023 aborts the packet: one extra o_wr_en word of zeros with o_wr_eop=1, then DONE.
  - o_err output (1 bit, reset 0) pulses with that o_end.
- Undefined: no counter and no o_err port; stalls are unbounded.

Test Plan:
- Reset values: hold i_rst=1 with random inputs -> all outputs 0. Release i_rst, then no grant for 5 cycles -> o_busy=0, o_port_rd=0.
- Header-only packet: port 3 FIFO holds header 0x0, grant sel=3 -> o_port_rd=16'h0008 for 1 cycle; one o_wr_en with sop=eop=1, o_wr_port=3; o_end 1 cycle, same cycle as eop.
- Streaming packet: port 0 holds header len=4 plus 4 words A0..A3, grant sel=0 -> 5 consecutive o_wr_en; data = header,A0..A3; sop on first, eop on fifth; o_end with fifth; o_busy low next cycle.
- Back-to-back ports with stall: port 1 len=2, then port 15 len=1; i_wr_full=1 for 3 cycles mid port-1 -> writes pause 3 cycles, no word lost or duplicated; o_wr_port 1 then 15; exactly two o_end pulses.
- Source underflow: port 5 len=3 with only 1 payload word present; FIFO refilled after 6 cycles -> stalls 6 cycles, then completes with 4 total writes.
- Reset mid-packet: assert i_rst during DATA of a len=8 packet -> outputs 0 same cycle, no o_end. After release, a grant on port 2 len=0 completes normally.
